// File: rtl/encode_pkg.sv
// Shared types and constants for the two-requester LZS encode scheduler.
package encode_pkg;

    localparam int LZF_WIDTH_DEF = 20;
    localparam int WORD_BYTES    = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        ABORT = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Number of 64-bit source words needed to carry len bytes.
    function automatic logic [31:0] ceil_words(input logic [31:0] len);
        return (len + 32'(WORD_BYTES - 1)) / 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/encode_sched_if.sv
// Requester, encode-core and completion signals of the scheduler in one bundle.
interface encode_sched_if
    import encode_pkg::*;
#(
    parameter int LZF_WIDTH = LZF_WIDTH_DEF
) ();

    logic                 req0_valid;
    logic [LZF_WIDTH-1:0] req0_len;
    logic                 req0_last;
    logic                 req0_ready;
    logic                 req1_valid;
    logic [LZF_WIDTH-1:0] req1_len;
    logic                 req1_last;
    logic                 req1_ready;
    logic                 src_sel;
    logic                 src_getn0;
    logic                 src_getn1;
    logic                 dst_putn0;
    logic                 dst_putn1;
    logic                 ce;
    logic [LZF_WIDTH-1:0] fi_cnt;
    logic                 m_last;
    logic                 m_src_getn;
    logic                 m_dst_putn;
    logic                 m_endn;
    logic                 done0;
    logic                 done1;
    logic [LZF_WIDTH-1:0] done_olen;
    logic                 done_err;

    modport slave (
        input  req0_valid, req0_len, req0_last, req1_valid, req1_len, req1_last,
        input  m_src_getn, m_dst_putn, m_endn,
        output req0_ready, req1_ready, src_sel, src_getn0, src_getn1,
        output dst_putn0, dst_putn1, ce, fi_cnt, m_last,
        output done0, done1, done_olen, done_err
    );

    modport master (
        output req0_valid, req0_len, req0_last, req1_valid, req1_len, req1_last,
        output m_src_getn, m_dst_putn, m_endn,
        input  req0_ready, req1_ready, src_sel, src_getn0, src_getn1,
        input  dst_putn0, dst_putn1, ce, fi_cnt, m_last,
        input  done0, done1, done_olen, done_err
    );

endinterface

// File: rtl/encode_rr_arb.sv
// Two-way round-robin arbiter; priority moves away from a requester once its job completes.
module encode_rr_arb
    import encode_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] valid_i,
    input  logic       upd_i,
    input  logic       served_i,
    output logic       gnt_o,
    output logic       gnt_vld_o
);

    logic prio_q;
    logic prio_d;

    // Favour the requester that was not served last.
    always_comb begin
        prio_d = upd_i ? !served_i : prio_q;
    end

    // Priority register, reset favours requester 0.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign gnt_vld_o = |valid_i;
    assign gnt_o     = (valid_i == 2'b11) ? prio_q : valid_i[1];

endmodule

// File: rtl/encode_sched.sv
// Shares one LZS encode core between two requesters: arbitration, core load, strobe
// steering, word counting, watchdog and per-job completion status.
module encode_sched
    import encode_pkg::*;
#(
    parameter int LZF_WIDTH = LZF_WIDTH_DEF,
    parameter int TIMEOUT   = 4096,
    parameter int TO_WIDTH  = 13
) (
    input  logic          clk,
    input  logic          rstn,
    encode_sched_if.slave bus
);

    state_e               state_q, state_d;
    logic [LZF_WIDTH-1:0] len_q, len_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic [LZF_WIDTH-1:0] olen_q, olen_d, limit_s;
    logic                 last_q, last_d, sel_q, sel_d, err_q, err_d, ab_q, ab_d;
    logic                 done0_q, done0_d, done1_q, done1_d, derr_q, derr_d;
    logic [TO_WIDTH-1:0]  wd_q, wd_d;
    logic                 gnt_s, gnt_vld_s, hs_s, run_s, done_st_s;
    logic                 get_s, put_s, end_s, overrun_s, timeout_s, get_fwd_s;

    encode_rr_arb u_arb (
        .clk       (clk),
        .rstn      (rstn),
        .valid_i   ({bus.req1_valid, bus.req0_valid}),
        .upd_i     (done_st_s),
        .served_i  (sel_q),
        .gnt_o     (gnt_s),
        .gnt_vld_o (gnt_vld_s)
    );

    assign limit_s   = LZF_WIDTH'(ceil_words(32'(len_q)));
    assign run_s     = (state_q == RUN);
    assign done_st_s = (state_q == DONE);
    assign hs_s      = (state_q == IDLE) && gnt_vld_s;
    assign get_s     = run_s && !bus.m_src_getn;
    assign put_s     = run_s && !bus.m_dst_putn;
    assign end_s     = run_s && !bus.m_endn;
    // A read beyond the job's word count is swallowed rather than passed to the source.
    assign overrun_s = get_s && (in_cnt_q == limit_s);
    assign get_fwd_s = get_s && !overrun_s;
    assign timeout_s = run_s && !get_s && !put_s && !end_s
                       && (wd_q == TO_WIDTH'(TIMEOUT - 1));

    assign bus.req0_ready = hs_s && !gnt_s;
    assign bus.req1_ready = hs_s && gnt_s;
    assign bus.ce         = run_s;
    assign bus.src_sel    = sel_q;
    assign bus.fi_cnt     = len_q;
    assign bus.m_last     = last_q;
    assign bus.src_getn0  = !(get_fwd_s && !sel_q);
    assign bus.src_getn1  = !(get_fwd_s && sel_q);
    assign bus.dst_putn0  = !(put_s && !sel_q);
    assign bus.dst_putn1  = !(put_s && sel_q);
    assign bus.done0      = done0_q;
    assign bus.done1      = done1_q;
    assign bus.done_olen  = olen_q;
    assign bus.done_err   = derr_q;

    // Job sequencing, counters and watchdog.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        last_d    = last_q;
        sel_d     = sel_q;
        err_d     = err_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        wd_d      = '0;
        ab_d      = 1'b0;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        olen_d    = olen_q;
        derr_d    = derr_q;
        case (state_q)
            IDLE: begin
                if (hs_s) begin
                    len_d     = gnt_s ? bus.req1_len : bus.req0_len;
                    last_d    = gnt_s ? bus.req1_last : bus.req0_last;
                    sel_d     = gnt_s;
                    err_d     = 1'b0;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = (len_d == LZF_WIDTH'(0)) ? DONE : LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: state_d = RUN;
            RUN: begin
                wd_d      = (get_s || put_s || end_s) ? '0 : wd_q + TO_WIDTH'(1);
                in_cnt_d  = get_fwd_s ? in_cnt_q + LZF_WIDTH'(1) : in_cnt_q;
                out_cnt_d = put_s ? out_cnt_q + LZF_WIDTH'(1) : out_cnt_q;
                if (overrun_s || timeout_s) begin
                    err_d   = 1'b1;
                    state_d = ABORT;
                end else if (end_s) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            ABORT: begin
                ab_d    = 1'b1;
                state_d = ab_q ? DONE : ABORT;
            end
            DONE: begin
                done0_d = !sel_q;
                done1_d = sel_q;
                olen_d  = out_cnt_q;
                derr_d  = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            len_q     <= '0;
            last_q    <= 1'b0;
            sel_q     <= 1'b0;
            err_q     <= 1'b0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            wd_q      <= '0;
            ab_q      <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            olen_q    <= '0;
            derr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            last_q    <= last_d;
            sel_q     <= sel_d;
            err_q     <= err_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            wd_q      <= wd_d;
            ab_q      <= ab_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            olen_q    <= olen_d;
            derr_q    <= derr_d;
        end
    end

endmodule

// File: tb/tb_encode_sched.sv
// Randomised and directed scoreboard bench for encode_sched with a job-level reference model.
module tb_encode_sched;

    localparam int LW  = 20;
    localparam int TMO = 8;

    typedef struct {
        bit sel;
        int olen;
        bit err;
    } exp_t;

    logic     clk = 1'b0;
    logic     rstn;
    int       n_checks = 0;
    int       n_fail = 0;
    bit       favour;
    bit [2:0] scr[$];
    exp_t     sb_q[$];

    encode_sched_if #(.LZF_WIDTH(LW)) bus ();

    encode_sched #(.LZF_WIDTH(LW), .TIMEOUT(TMO), .TO_WIDTH(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Job outcome from the script: words = ceil(len/8), a read past that aborts,
    // TMO consecutive silent cycles abort, endn finishes. Script cells are {get,put,end}.
    function automatic void predict(input int len, output int olen, output bit err,
                                    output int ncyc, output int blk);
        int lim, gets, idle;
        bit [2:0] s;
        lim = (len + 7) / 8;
        gets = 0; idle = 0; olen = 0; err = 1'b0; ncyc = 0; blk = -1;
        if (len == 0) return;
        for (int i = 0; i < scr.size() + TMO + 1; i++) begin
            s = (i < scr.size()) ? scr[i] : 3'b000;
            ncyc = i + 1;
            if (s[2] && gets == lim) begin
                err = 1'b1; blk = i;
                if (s[1]) olen++;
                return;
            end
            if (s[2]) gets++;
            if (s[1]) olen++;
            if (s == 3'b000) begin
                idle++;
                if (idle == TMO) begin
                    err = 1'b1;
                    return;
                end
            end else begin
                idle = 0;
            end
            if (s[0]) return;
        end
    endfunction

    task automatic run_job(input bit v0, input bit v1, input int l0, input int l1,
                           input bit la0, input bit la1);
        bit sel, err, gf, pf;
        int len, olen, ncyc, blk, k;
        bit [2:0] s;
        @(negedge clk);
        bus.req0_valid = v0; bus.req0_len = LW'(l0); bus.req0_last = la0;
        bus.req1_valid = v1; bus.req1_len = LW'(l1); bus.req1_last = la1;
        sel = (v0 && v1) ? favour : v1;
        #1 check("ready", 64'({bus.req1_ready, bus.req0_ready}), sel ? 64'd2 : 64'd1);
        @(negedge clk);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        len = sel ? l1 : l0;
        predict(len, olen, err, ncyc, blk);
        sb_q.push_back('{sel: sel, olen: olen, err: err});
        favour = !sel;
        #1 check("load", 64'({bus.src_sel, bus.fi_cnt, bus.m_last, bus.ce}),
                 64'({sel, LW'(len), (sel ? la1 : la0), 1'b0}));
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            s = (i < scr.size()) ? scr[i] : 3'b000;
            bus.m_src_getn = !s[2]; bus.m_dst_putn = !s[1]; bus.m_endn = !s[0];
            gf = s[2] && (i != blk);
            pf = s[1];
            #1 check("run_strobes",
                     64'({bus.ce, bus.src_getn0, bus.src_getn1, bus.dst_putn0, bus.dst_putn1}),
                     64'({1'b1, !(gf && !sel), !(gf && sel), !(pf && !sel), !(pf && sel)}));
        end
        k = 0;
        do begin
            @(negedge clk);
            bus.m_src_getn = 1'b0; bus.m_dst_putn = 1'b0; bus.m_endn = 1'b1;
            k++;
            #1 check("blocked",
                     64'({bus.ce, bus.src_getn0, bus.src_getn1, bus.dst_putn0, bus.dst_putn1}),
                     64'h0F);
        end while (!(bus.done0 || bus.done1) && k < 10);
        bus.m_src_getn = 1'b1; bus.m_dst_putn = 1'b1; bus.m_endn = 1'b1;
        check("done_latency", 64'(k), (len == 0) ? 64'd1 : (err ? 64'd4 : 64'd2));
    endtask

    task automatic gen_script();
        int n;
        bit [2:0] s;
        scr.delete();
        n = $urandom_range(1, 10);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(5, 9)) scr.push_back(3'b000);
            end
            s = {($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                 ((i == n - 1) && ($urandom_range(0, 3) != 0))};
            scr.push_back(s);
        end
    endtask

    // Scoreboard monitor: every completion pulse must match the oldest expected job.
    always @(negedge clk) begin
        exp_t e;
        if (rstn && (bus.done0 || bus.done1)) begin
            if (sb_q.size() == 0) begin
                check("done_unexpected", 64'({bus.done1, bus.done0}), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("done_sel", 64'({bus.done1, bus.done0}), e.sel ? 64'd2 : 64'd1);
                check("done_olen", 64'(bus.done_olen), 64'(e.olen));
                check("done_err", 64'(bus.done_err), 64'(e.err));
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int l0, l1;
        bit v0, v1;
        rstn = 1'b0; favour = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_len = '0; bus.req0_last = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_len = '0; bus.req1_last = 1'b0;
        bus.m_src_getn = 1'b1; bus.m_dst_putn = 1'b1; bus.m_endn = 1'b1;
        repeat (3) @(negedge clk);
        #1 check("reset_state",
                 64'({bus.ce, bus.fi_cnt, bus.m_last, bus.src_sel, bus.src_getn0, bus.src_getn1,
                      bus.dst_putn0, bus.dst_putn1, bus.req0_ready, bus.req1_ready,
                      bus.done0, bus.done1, bus.done_olen, bus.done_err}),
                 64'({1'b0, 20'd0, 1'b0, 1'b0, 4'hF, 2'b00, 2'b00, 20'd0, 1'b0}));
        @(negedge clk);
        rstn = 1'b1;

        // Contention from reset: 0, 1, 0.
        scr = '{3'b110, 3'b001};
        run_job(1'b1, 1'b1, 20, 30, 1'b1, 1'b0);
        run_job(1'b1, 1'b1, 20, 30, 1'b1, 1'b0);
        run_job(1'b1, 1'b1, 20, 30, 1'b0, 1'b1);
        // Single job: 13 reads, 5 writes, end.
        scr.delete();
        repeat (13) scr.push_back(3'b100);
        repeat (5) scr.push_back(3'b010);
        scr.push_back(3'b001);
        run_job(1'b1, 1'b0, 100, 0, 1'b1, 1'b0);
        // Zero length.
        run_job(1'b0, 1'b1, 0, 0, 1'b0, 1'b1);
        // Overrun on the third read of a 16-byte job.
        scr = '{3'b110, 3'b100, 3'b100};
        run_job(1'b1, 1'b0, 16, 0, 1'b0, 1'b0);
        // Length boundaries.
        scr = '{3'b100, 3'b100};
        run_job(1'b0, 1'b1, 0, 8, 1'b0, 1'b0);
        scr = '{3'b100, 3'b100, 3'b011};
        run_job(1'b1, 1'b0, 9, 0, 1'b0, 1'b0);
        scr = '{3'b100, 3'b011};
        run_job(1'b0, 1'b1, 0, (1 << LW) - 1, 1'b0, 1'b1);
        // Silent core times out; a strobe in the 7th cycle restarts the watchdog.
        scr.delete();
        run_job(1'b1, 1'b0, 50, 0, 1'b0, 1'b0);
        repeat (6) scr.push_back(3'b000);
        scr.push_back(3'b010);
        repeat (7) scr.push_back(3'b000);
        scr.push_back(3'b001);
        run_job(1'b0, 1'b1, 0, 50, 1'b0, 1'b0);

        // Reset in the middle of RUN abandons the job silently.
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_len = 20'd200; bus.req0_last = 1'b0;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            bus.m_src_getn = 1'b0;
        end
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1; favour = 1'b0;
        #1 check("reset_mid_run",
                 64'({bus.ce, bus.src_getn0, bus.src_getn1, bus.dst_putn0, bus.dst_putn1,
                      bus.done1, bus.done0}), 64'h3C);
        check("reset_mid_regs", 64'({bus.done_olen, bus.done_err, bus.fi_cnt, bus.src_sel}), 64'd0);
        bus.m_src_getn = 1'b1;
        repeat (4) @(negedge clk);
        scr = '{3'b010, 3'b001};
        run_job(1'b1, 1'b1, 12, 24, 1'b0, 1'b0);

        // Randomised jobs.
        for (int j = 0; j < 40; j++) begin
            v0 = ($urandom_range(0, 1) == 1);
            v1 = !v0 || ($urandom_range(0, 1) == 1);
            l0 = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 48);
            l1 = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 48);
            gen_script();
            run_job(v0, v1, l0, l1, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
